// File: rtl/cryp_defs_pkg.sv
// Shared definitions for the 4-lane x 16-bit chained cipher (encrypt and decrypt paths).
package cryp_defs;

    localparam int unsigned LANE_W = 16;
    localparam int unsigned LANES  = 4;
    localparam int unsigned WORD_W = 65;
    localparam int unsigned ROT_W  = 4;

    localparam logic [LANE_W-1:0] CRYP_IV = 16'h1234;

    typedef logic [LANES-1:0][LANE_W-1:0] lanes_t;
    typedef logic [LANES-1:0][ROT_W-1:0]  rots_t;

    // Popcount of a key lane, kept at 4 bits: a full-ones lane (16) wraps to 0, an identity rotate.
    function automatic logic [ROT_W-1:0] rot_amount(input logic [LANE_W-1:0] k);
        logic [ROT_W-1:0] cnt;
        cnt = '0;
        for (int unsigned i = 0; i < LANE_W; i++) begin
            cnt = cnt + ROT_W'(k[i]);
        end
        return cnt;
    endfunction

    function automatic logic [LANE_W-1:0] rotr16(input logic [LANE_W-1:0] v,
                                                 input logic [ROT_W-1:0]  r);
        return (v >> r) | (v << (5'd16 - {1'b0, r}));
    endfunction

endpackage

// File: rtl/cryp_lane_inv.sv
// Per-lane inverse cipher helpers: key popcount (stage 1) and xor/rotate-right (stage 2).
module cryp_lane_inv
    import cryp_defs::*;
(
    input  logic [LANE_W-1:0] cnt_key,
    output logic [ROT_W-1:0]  rot,
    input  logic [LANE_W-1:0] e,
    input  logic [LANE_W-1:0] k,
    input  logic [ROT_W-1:0]  rot_amt,
    output logic [LANE_W-1:0] x
);

    always_comb begin
        rot = rot_amount(cnt_key);
        x   = rotr16(e ^ k, rot_amt);
    end

endmodule

// File: rtl/decrypt_compute.sv
// Three-stage decrypt pipeline for 65-bit cipher words with valid/ready flow control
// and a count of completed frames.
module decrypt_compute
    import cryp_defs::*;
#(
    parameter logic [LANE_W-1:0] IV = CRYP_IV
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              decrypt_req,
    output logic              decrypt_ready,
    input  logic [63:0]       key,
    input  logic [WORD_W-1:0] enc_data,
    output logic [WORD_W-1:0] clr_data,
    output logic              clr_data_valid,
    input  logic              clr_data_ready,
    output logic [15:0]       frame_cnt
);

    logic              s1_valid;
    logic [WORD_W-1:0] s1_enc;
    lanes_t            s1_key;
    rots_t             s1_rot;

    logic              s2_valid;
    logic              s2_last;
    lanes_t            s2_e;
    lanes_t            s2_x;

    rots_t             in_rot;
    lanes_t            s1_x;
    lanes_t            clr_next;

    logic              s3_load;
    logic              s2_load;
    logic              s1_load;
    logic              in_fire;
    logic              out_fire;

    for (genvar i = 0; i < LANES; i++) begin : g_lane
        cryp_lane_inv u_lane (
            .cnt_key (key[LANE_W*i +: LANE_W]),
            .rot     (in_rot[i]),
            .e       (s1_enc[LANE_W*i +: LANE_W]),
            .k       (s1_key[i]),
            .rot_amt (s1_rot[i]),
            .x       (s1_x[i])
        );
    end

    // A stage may load when it is empty or its successor is taking its word this cycle;
    // this chain is what makes decrypt_ready combinational from clr_data_ready.
    always_comb begin
        s3_load       = !clr_data_valid || clr_data_ready;
        s2_load       = !s2_valid || s3_load;
        s1_load       = !s1_valid || s2_load;
        decrypt_ready = s1_load;
        in_fire       = decrypt_req && decrypt_ready;
        out_fire      = clr_data_valid && clr_data_ready;
    end

    // Chaining uses the previous lane's cipher text, so every lane resolves in parallel.
    always_comb begin
        clr_next    = '0;
        clr_next[0] = s2_x[0] ^ IV;
        for (int unsigned i = 1; i < LANES; i++) begin
            clr_next[i] = s2_x[i] ^ s2_e[i-1];
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            s1_valid <= 1'b0;
            s1_enc   <= '0;
            s1_key   <= '0;
            s1_rot   <= '0;
        end else if (s1_load) begin
            s1_valid <= in_fire;
            if (in_fire) begin
                s1_enc <= enc_data;
                s1_key <= key;
                s1_rot <= in_rot;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            s2_valid <= 1'b0;
            s2_last  <= 1'b0;
            s2_e     <= '0;
            s2_x     <= '0;
        end else if (s2_load) begin
            s2_valid <= s1_valid;
            if (s1_valid) begin
                s2_last <= s1_enc[WORD_W-1];
                s2_e    <= s1_enc[WORD_W-2:0];
                s2_x    <= s1_x;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            clr_data_valid <= 1'b0;
            clr_data       <= '0;
        end else if (s3_load) begin
            clr_data_valid <= s2_valid;
            if (s2_valid) begin
                clr_data <= {s2_last, clr_next};
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            frame_cnt <= '0;
        end else if (out_fire && clr_data[WORD_W-1]) begin
            frame_cnt <= frame_cnt + 16'd1;
        end
    end

endmodule
